// File: rtl/capture_if.sv
// Pixel stream from the OV7670 receiver and the linear write port into the frame BRAM.
interface capture_if #(
    parameter int PXL_WIDTH  = 16,
    parameter int ADDR_WIDTH = 17
);
    logic                  i_vs;
    logic                  i_pixel_valid;
    logic [PXL_WIDTH-1:0]  i_pixel_data;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [PXL_WIDTH-1:0]  o_wr_data;

    modport master (
        output i_vs, i_pixel_valid, i_pixel_data,
        input  o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        input  i_vs, i_pixel_valid, i_pixel_data,
        output o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/capture_ctrl.sv
// OV7670 frame capture sequencer with a ping-pong frame buffer that swaps only
// at a display frame start and only after a complete, correctly sized frame.
module capture_ctrl #(
    parameter int H_WIDTH    = 320,
    parameter int V_WIDTH    = 240,
    parameter int PXL_WIDTH  = 16,
    parameter int ADDR_WIDTH = $clog2(H_WIDTH*V_WIDTH),
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start_capture,
    input  logic                  i_continuous,
    input  logic                  i_stop,
    input  logic                  i_disp_frame_start,
    capture_if.slave              bus,
    output logic                  o_wr_bank,
    output logic                  o_rd_bank,
    output logic                  o_frame_done,
    output logic                  o_frame_err,
    output logic [FCNT_WIDTH-1:0] o_frame_count,
    output logic [4:0]            o_state
);
    localparam int TOTAL_I = H_WIDTH * V_WIDTH;
    localparam int CNT_W   = $clog2(TOTAL_I + 2);
    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(TOTAL_I);
    localparam logic [CNT_W-1:0] TOTAL_P1 = CNT_W'(TOTAL_I + 1);

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ARM     = 5'b00010,
        ST_WAIT_VF = 5'b00100,
        ST_CAPTURE = 5'b01000,
        ST_DONE    = 5'b10000
    } state_t;

    state_t                  r_state;
    logic                    r_vs_d;
    logic                    r_pending;
    logic [CNT_W-1:0]        r_pix_cnt;
    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [PXL_WIDTH-1:0]    r_wr_data;
    logic                    r_wr_bank;
    logic                    r_rd_bank;
    logic                    r_frame_done;
    logic                    r_frame_err;
    logic [FCNT_WIDTH-1:0]   r_frame_count;

    logic                    w_vs_rise;
    logic                    w_vs_fall;
    logic [CNT_W-1:0]        w_cnt_inc;

    assign w_vs_rise = bus.i_vs & ~r_vs_d;
    assign w_vs_fall = ~bus.i_vs & r_vs_d;

    // Pixel count including this cycle's strobe, saturating one past a full frame.
    always_comb begin
        w_cnt_inc = r_pix_cnt;
        if (bus.i_pixel_valid && (r_pix_cnt != TOTAL_P1)) begin
            w_cnt_inc = r_pix_cnt + CNT_W'(1);
        end else begin
            w_cnt_inc = r_pix_cnt;
        end
    end

    // Capture FSM, bank swap and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_vs_d        <= 1'b0;
            r_pending     <= 1'b0;
            r_pix_cnt     <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b1;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_vs_d       <= bus.i_vs;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            if (i_stop) begin
                r_state <= ST_IDLE;
            end else begin
                // pending is sampled registered, so a frame finishing this cycle swaps at the next disp pulse
                if (i_disp_frame_start && r_pending) begin
                    r_rd_bank <= r_wr_bank;
                    r_wr_bank <= ~r_wr_bank;
                    r_pending <= 1'b0;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (i_start_capture || i_continuous) r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_vs_rise) r_state <= ST_WAIT_VF;
                    end
                    ST_WAIT_VF: begin
                        if (w_vs_fall) begin
                            r_state   <= ST_CAPTURE;
                            r_pix_cnt <= '0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (bus.i_pixel_valid && (r_pix_cnt < TOTAL)) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_pix_cnt[ADDR_WIDTH-1:0];
                            r_wr_data <= bus.i_pixel_data;
                        end
                        r_pix_cnt <= w_cnt_inc;
                        if (w_vs_rise) begin
                            if (w_cnt_inc == TOTAL) begin
                                r_frame_done  <= 1'b1;
                                r_frame_count <= r_frame_count + FCNT_WIDTH'(1);
                                r_pending     <= 1'b1;
                                r_state       <= ST_DONE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_WAIT_VF;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (!r_pending) r_state <= i_continuous ? ST_ARM : ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_wr_en   = r_wr_en;
    assign bus.o_wr_addr = r_wr_addr;
    assign bus.o_wr_data = r_wr_data;
    assign o_wr_bank     = r_wr_bank;
    assign o_rd_bank     = r_rd_bank;
    assign o_frame_done  = r_frame_done;
    assign o_frame_err   = r_frame_err;
    assign o_frame_count = r_frame_count;
    assign o_state       = r_state;
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sequences OV7670 frame capture: arms on a start request, aligns to a clean VSYNC boundary, and turns receiver pixel strobes into linear BRAM write addresses.
- Manages a two-bank ping-pong frame buffer. The camera writes one bank while the VGA side reads the other. Banks swap only at a display frame start, and only after a complete, correctly sized frame.
- Sits between the OV7670 receiver (synchronized VS level, pixel strobe and data) and the dual-bank frame BRAM / VGA reader.

Parameters:
- H_WIDTH, 320, active pixels per line
- V_WIDTH, 240, active lines per frame
- PXL_WIDTH, 16, pixel data width (RGB565)
- ADDR_WIDTH, $clog2(H_WIDTH*V_WIDTH), linear write address width
- FCNT_WIDTH, 16, frame counter width

Ports:
- i_clk  in  1  system clock; the only clock
- i_reset  in  1  synchronous, active-high reset
- i_start_capture  in  1  1-cycle pulse; request a single-frame capture
- i_continuous  in  1  level; capture every frame while high
- i_stop  in  1  1-cycle pulse; abort the current capture
- i_vs  in  1  VSYNC level, already synchronized to i_clk; high = vertical blank
- i_pixel_valid  in  1  1-cycle strobe; one complete pixel available
- i_pixel_data  in  PXL_WIDTH  pixel value, qualified by i_pixel_valid
- i_disp_frame_start  in  1  1-cycle pulse from the VGA timing block at the top of a display frame
- o_wr_en  out  1  BRAM write enable
- o_wr_addr  out  ADDR_WIDTH  linear BRAM write address
- o_wr_data  out  PXL_WIDTH  BRAM write data
- o_wr_bank  out  1  bank the camera writes
- o_rd_bank  out  1  bank the display reads
- o_frame_done  out  1  1-cycle pulse; good frame captured
- o_frame_err  out  1  1-cycle pulse; frame pixel count was not H_WIDTH*V_WIDTH
- o_frame_count  out  FCNT_WIDTH  count of good frames captured
- o_state  out  5  one-hot present state

Behaviour:
- Reset values:
  - state = IDLE (o_state = 5'b00001)
  - o_wr_en = 0, o_wr_addr = 0, o_wr_data = 0
  - o_wr_bank = 0, o_rd_bank = 1
  - o_frame_done = 0, o_frame_err = 0, o_frame_count = 0
  - internal pending = 0, pix_cnt = 0, vs_d = 0
- VS edges: vs_d registers i_vs every cycle. vs_rise = i_vs & ~vs_d; vs_fall = ~i_vs & vs_d.
- States (one-hot) and transitions:
  - IDLE (00001): on i_start_capture or i_continuous -> ARM.
  - ARM (00010): on vs_rise -> WAIT_VS_FALL. A capture never starts mid-frame.
  - WAIT_VS_FALL (00100): on vs_fall -> CAPTURE, and pix_cnt <= 0.
  - CAPTURE (01000): on i_pixel_valid with pix_cnt < H_WIDTH*V_WIDTH, the next cycle drives o_wr_en = 1, o_wr_addr = pix_cnt, o_wr_data = i_pixel_data; pix_cnt increments. Strobes with pix_cnt >= H*V are counted but not written (pix_cnt saturates at H*V+1).
    - On vs_rise with pix_cnt == H*V: pulse o_frame_done, increment o_frame_count (wraps), set pending = 1, go -> DONE.
    - On vs_rise with pix_cnt != H*V: pulse o_frame_err, go -> WAIT_VS_FALL. The bad frame is recaptured into the same bank; no count change.
  - DONE (10000): wait for pending == 0. Then -> ARM if i_continuous, else -> IDLE. Frames arriving during DONE are skipped.
- Bank swap: on i_disp_frame_start with pending == 1, o_rd_bank <= o_wr_bank, o_wr_bank <= ~o_wr_bank, pending <= 0. This takes 1 cycle; o_wr_bank and o_rd_bank always differ.
- Simultaneous events:
  - i_pixel_valid and vs_rise in the same cycle: the pixel is written and counted first, then the end-of-frame check uses the incremented count.
  - pending being set and i_disp_frame_start in the same cycle: no swap that cycle; the swap happens at the next display frame start.
  - i_stop has priority over every other event.
- i_stop, from any state: next state = IDLE, o_wr_en = 0 from the next cycle, the partial frame is discarded, and pending, the banks and o_frame_count are unchanged. A pending completed frame still swaps later.
- i_start_capture outside IDLE is ignored. Dropping i_continuous mid-capture finishes the current frame, then returns to IDLE.
- Latency: i_pixel_valid -> o_wr_en is 1 cycle. o_frame_done / o_frame_err assert 1 cycle after the vs_rise cycle. All outputs are registered.

Test Plan:
- Use H_WIDTH = 4, V_WIDTH = 2. Single capture: reset; start pulse while i_vs = 0; VS high then low; 8 strobes with data 0x1000..0x1007; VS high -> writes at addr 0..7 carry the matching data on bank 0; o_frame_done pulses once; o_frame_count = 1; state = DONE. A later i_disp_frame_start gives o_rd_bank = 0, o_wr_bank = 1, state = IDLE.
- Mid-frame start: start pulse while i_vs = 0 with strobes already arriving -> no write until a full VS high/low cycle has occurred; the first write lands at addr 0.
- Short and long frames: 7 strobes then vs_rise -> o_frame_err pulse, count unchanged, state = WAIT_VS_FALL, bank unchanged. 10 strobes -> only addr 0..7 written, then o_frame_err.
- Continuous with slow display: i_continuous = 1, three camera frames before any i_disp_frame_start -> one o_frame_done; the 2nd and 3rd frames are skipped (no writes); a disp pulse swaps the banks and the controller re-arms.
- Simultaneous events: pixel strobe #8 in the same cycle as vs_rise -> addr 7 written and o_frame_done pulses. pending being set in the same cycle as i_disp_frame_start -> swap only at the next disp pulse.
- Stop and reset: i_stop after 3 strobes -> IDLE next cycle, no further o_wr_en, banks and count unchanged. i_reset asserted mid-CAPTURE -> all outputs return to their reset values on the next clock.
